// File: rtl/alu_seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_muldiv                                                  |
// | Brief    : EX-stage integer ALU with iterative RV32M multiply/divide.      |
// |            Simple ops complete in one cycle; MUL/DIV iterate one bit per   |
// |            cycle behind a valid/ready handshake. Result is registered.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_seq_muldiv #(
  parameter int XLEN = 32,
  parameter int OPW  = 5,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero,
  output logic            busy
);

  // Counter runs 0..XLEN: XLEN iteration cycles plus one sign-fix/select cycle.
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   c_cnt_last = CW'(XLEN);
  localparam logic [XLEN-1:0] c_min_int  = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [OPW-1:0] c_op_add    = OPW'(0);
  localparam logic [OPW-1:0] c_op_sll    = OPW'(1);
  localparam logic [OPW-1:0] c_op_slt    = OPW'(2);
  localparam logic [OPW-1:0] c_op_sltu   = OPW'(3);
  localparam logic [OPW-1:0] c_op_xor    = OPW'(4);
  localparam logic [OPW-1:0] c_op_srl    = OPW'(5);
  localparam logic [OPW-1:0] c_op_sra    = OPW'(6);
  localparam logic [OPW-1:0] c_op_or     = OPW'(7);
  localparam logic [OPW-1:0] c_op_and    = OPW'(8);
  localparam logic [OPW-1:0] c_op_sub    = OPW'(9);
  localparam logic [OPW-1:0] c_op_passb  = OPW'(10);
  localparam logic [OPW-1:0] c_op_mul    = OPW'(11);
  localparam logic [OPW-1:0] c_op_mulh   = OPW'(12);
  localparam logic [OPW-1:0] c_op_mulhsu = OPW'(13);
  localparam logic [OPW-1:0] c_op_mulhu  = OPW'(14);
  localparam logic [OPW-1:0] c_op_div    = OPW'(15);
  localparam logic [OPW-1:0] c_op_divu   = OPW'(16);
  localparam logic [OPW-1:0] c_op_rem    = OPW'(17);
  localparam logic [OPW-1:0] c_op_remu   = OPW'(18);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  // Registered state and its next-state values
  state_t          state_q,     state_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [XLEN-1:0] hi_q,        hi_d;       // mul: partial product high / div: remainder
  logic [XLEN-1:0] lo_q,        lo_d;       // mul: multiplier / div: dividend -> quotient
  logic [XLEN-1:0] opnd_q,      opnd_d;     // mul: multiplicand / div: divisor
  logic            neg_q,       neg_d;      // final result needs negation
  logic            sel_hi_q,    sel_hi_d;   // take hi half (MULH*, REM*) instead of lo
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q,    result_d;
  logic            div_zero_q,  div_zero_d;

  // Combinational helpers
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_simple_res;
  logic [XLEN-1:0]   w_special_res;
  logic              w_accept;
  logic              w_free;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_div_special;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN:0]     w_div_diff;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_mul_fin;
  logic [XLEN-1:0]   w_div_sel;
  logic [XLEN-1:0]   w_div_fin;

  assign w_shamt   = b[SHW-1:0];
  assign w_free    = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_IDLE) && w_free && !flush;
  assign w_accept  = in_valid && in_ready;

  assign w_is_mul  = (op == c_op_mul) || (op == c_op_mulh) ||
                     (op == c_op_mulhsu) || (op == c_op_mulhu);
  assign w_is_div  = (op == c_op_div) || (op == c_op_divu) ||
                     (op == c_op_rem) || (op == c_op_remu);
  assign w_b_zero  = (b == '0);
  assign w_ovf     = ((op == c_op_div) || (op == c_op_rem)) &&
                     (a == c_min_int) && (b == '1);
  assign w_div_special = w_is_div && (w_b_zero || w_ovf);

  // Operand signedness per op; MUL low half is sign-agnostic, treated as s*s.
  assign w_a_signed = (op == c_op_mul) || (op == c_op_mulh) || (op == c_op_mulhsu) ||
                      (op == c_op_div) || (op == c_op_rem);
  assign w_b_signed = (op == c_op_mul) || (op == c_op_mulh) ||
                      (op == c_op_div) || (op == c_op_rem);
  assign w_a_neg    = w_a_signed && a[XLEN-1];
  assign w_b_neg    = w_b_signed && b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;

  // Shift-add step: add multiplicand when the current multiplier bit is set, shift right.
  assign w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring step: shift next dividend bit into the remainder and trial-subtract.
  assign w_div_shift = {hi_q, lo_q[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
  assign w_div_ge    = !w_div_diff[XLEN];

  // Sign correction and half/quotient-remainder selection on completion
  assign w_prod     = {hi_q, lo_q};
  assign w_prod_fix = neg_q ? -w_prod : w_prod;
  assign w_mul_fin  = sel_hi_q ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
  assign w_div_sel  = sel_hi_q ? hi_q : lo_q;
  assign w_div_fin  = neg_q ? -w_div_sel : w_div_sel;

  // Single-cycle ALU result for ops 0-10; anything else here yields zero.
  always_comb begin
    w_simple_res = '0;
    case (op)
      c_op_add:   w_simple_res = a + b;
      c_op_sll:   w_simple_res = a << w_shamt;
      c_op_slt:   w_simple_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      c_op_sltu:  w_simple_res = {{(XLEN-1){1'b0}}, (a < b)};
      c_op_xor:   w_simple_res = a ^ b;
      c_op_srl:   w_simple_res = a >> w_shamt;
      c_op_sra:   w_simple_res = $unsigned($signed(a) >>> w_shamt);
      c_op_or:    w_simple_res = a | b;
      c_op_and:   w_simple_res = a & b;
      c_op_sub:   w_simple_res = a - b;
      c_op_passb: w_simple_res = b;
      default:    w_simple_res = '0;
    endcase
  end

  // Divide-by-zero and MIN_INT/-1 results that bypass the iterative divider.
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = ((op == c_op_div) || (op == c_op_divu)) ? '1 : a;
    end else if (op == c_op_div) begin
      w_special_res = c_min_int;
    end
  end

  // Next-state logic for the control FSM, datapath registers and result register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    sel_hi_d    = sel_hi_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    div_zero_d  = div_zero_q;

    // Consumer takes the pending result; may be re-set below by a new completion.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = w_b_mag;
            opnd_d   = w_a_mag;
            neg_d    = w_a_neg ^ w_b_neg;
            sel_hi_d = (op != c_op_mul);
          end else if (w_is_div && !w_div_special) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = w_a_mag;
            opnd_d   = w_b_mag;
            sel_hi_d = (op == c_op_rem) || (op == c_op_remu);
            // Remainder takes the dividend's sign; quotient takes the XOR of signs.
            neg_d    = ((op == c_op_rem) || (op == c_op_remu)) ? w_a_neg : (w_a_neg ^ w_b_neg);
          end else begin
            out_valid_d = 1'b1;
            result_d    = w_div_special ? w_special_res : w_simple_res;
            div_zero_d  = w_div_special && w_b_zero;
          end
        end
      end

      S_MUL: begin
        if (cnt_q != c_cnt_last) begin
          hi_d  = w_mul_sum[XLEN:1];
          lo_d  = {w_mul_sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q + CW'(1);
        end else if (w_free) begin
          out_valid_d = 1'b1;
          result_d    = w_mul_fin;
          div_zero_d  = 1'b0;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end

      S_DIV: begin
        if (cnt_q != c_cnt_last) begin
          hi_d  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], w_div_ge};
          cnt_d = cnt_q + CW'(1);
        end else if (w_free) begin
          out_valid_d = 1'b1;
          result_d    = w_div_fin;
          div_zero_d  = 1'b0;
          state_d     = S_IDLE;
          cnt_d       = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Flush kills anything in flight or pending, overriding completion and consume.
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      sel_hi_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      sel_hi_q    <= sel_hi_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign div_zero  = div_zero_q;
  assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
